// File: rtl/acq_run_sequencer_if.sv
// Signal bundle between the host register file / acquisition controller and
// the run sequencer. The sequencer connects through the slave modport; the
// environment (register file plus controller) uses the master modport.
interface acq_run_sequencer_if;
   logic       GO;
   logic       CANCEL;
   logic [7:0] NUM_RUNS;
   logic [7:0] TIMEOUT_REVS;
   logic       FD_INDEX_IN;
   logic       ACQ_WAITING;
   logic       ACQ_ACQUIRING;
   logic       SR_R_FULL;
   logic       ACQ_START;
   logic       ACQ_ABORT;
   logic       BUSY;
   logic       DONE;
   logic [7:0] RUN_COUNT;
   logic [2:0] ERR;

   modport master (
      output GO, CANCEL, NUM_RUNS, TIMEOUT_REVS, FD_INDEX_IN,
             ACQ_WAITING, ACQ_ACQUIRING, SR_R_FULL,
      input  ACQ_START, ACQ_ABORT, BUSY, DONE, RUN_COUNT, ERR
   );

   modport slave (
      input  GO, CANCEL, NUM_RUNS, TIMEOUT_REVS, FD_INDEX_IN,
             ACQ_WAITING, ACQ_ACQUIRING, SR_R_FULL,
      output ACQ_START, ACQ_ABORT, BUSY, DONE, RUN_COUNT, ERR
   );
endinterface

// File: rtl/acq_run_sequencer.sv
// Acquisition run sequencer: issues START for a programmed number of runs,
// supervises each run with acknowledge and index-revolution timeouts, and
// forces ABORT on timeout or host cancel. All outputs are registered and are
// derived from the next state so they line up with the state they describe.
module acq_run_sequencer #(
   parameter int ACK_TIMEOUT  = 16,
   parameter int ABORT_CYCLES = 4
) (
   input  logic               CLK_MASTER,
   input  logic               RESET,
   acq_run_sequencer_if.slave bus
);
   localparam int ACK_W   = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
   localparam int ABORT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
   localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [ABORT_W-1:0] ABORT_LAST = ABORT_W'(ABORT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT_ACK, S_RUNNING, S_ABORTING, S_FINISH
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         target_q, target_d;
   logic [7:0]         timeout_revs_q, timeout_revs_d;
   logic [7:0]         run_count_q, run_count_d;
   logic [2:0]         err_q, err_d;
   logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
   logic [7:0]         rev_cnt_q, rev_cnt_d;
   logic [ABORT_W-1:0] abort_cnt_q, abort_cnt_d;
   logic               cancel_flag_q, cancel_flag_d;
   logic               idx_prev_q, idx_prev_d;
   logic               acq_start_q, acq_start_d;
   logic               acq_abort_q, acq_abort_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic       idx_rise;
   logic [7:0] rev_cnt_cur;
   logic       idx_timeout;
   logic       status_active;
   logic [7:0] run_count_inc;

   // State register plus every registered output and counter
   always_ff @(posedge CLK_MASTER) begin
      if (RESET) begin
         state_q        <= S_IDLE;
         target_q       <= 8'd0;
         timeout_revs_q <= 8'd0;
         run_count_q    <= 8'd0;
         err_q          <= 3'd0;
         ack_cnt_q      <= '0;
         rev_cnt_q      <= 8'd0;
         abort_cnt_q    <= '0;
         cancel_flag_q  <= 1'b0;
         idx_prev_q     <= 1'b0;
         acq_start_q    <= 1'b0;
         acq_abort_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         timeout_revs_q <= timeout_revs_d;
         run_count_q    <= run_count_d;
         err_q          <= err_d;
         ack_cnt_q      <= ack_cnt_d;
         rev_cnt_q      <= rev_cnt_d;
         abort_cnt_q    <= abort_cnt_d;
         cancel_flag_q  <= cancel_flag_d;
         idx_prev_q     <= idx_prev_d;
         acq_start_q    <= acq_start_d;
         acq_abort_q    <= acq_abort_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   // Next-state and datapath: run tracking, timeouts, cancel priority
   always_comb begin
      idx_rise      = bus.FD_INDEX_IN & ~idx_prev_q;
      status_active = bus.ACQ_WAITING | bus.ACQ_ACQUIRING;
      run_count_inc = run_count_q + 8'd1;
      // Revolution count including an edge seen this cycle (saturating)
      rev_cnt_cur   = rev_cnt_q;
      if ((state_q == S_WAIT_ACK || state_q == S_RUNNING) && idx_rise && rev_cnt_q != 8'hFF)
         rev_cnt_cur = rev_cnt_q + 8'd1;
      idx_timeout   = (timeout_revs_q != 8'd0) && (rev_cnt_cur >= timeout_revs_q);

      state_d        = state_q;
      target_d       = target_q;
      timeout_revs_d = timeout_revs_q;
      run_count_d    = run_count_q;
      err_d          = err_q;
      ack_cnt_d      = ack_cnt_q;
      rev_cnt_d      = rev_cnt_cur;
      abort_cnt_d    = abort_cnt_q;
      cancel_flag_d  = cancel_flag_q;
      idx_prev_d     = bus.FD_INDEX_IN;

      case (state_q)
         S_IDLE: begin
            if (bus.GO) begin
               target_d       = (bus.NUM_RUNS == 8'd0) ? 8'd1 : bus.NUM_RUNS;
               timeout_revs_d = bus.TIMEOUT_REVS;
               run_count_d    = 8'd0;
               err_d          = 3'd0;
               state_d        = S_ARM;
            end
         end
         S_ARM: begin
            ack_cnt_d = '0;
            rev_cnt_d = 8'd0;
            state_d   = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (status_active) begin
               state_d = S_RUNNING;
            end else if (idx_timeout) begin
               err_d[1]      = 1'b1;
               state_d       = S_ABORTING;
               abort_cnt_d   = '0;
               cancel_flag_d = 1'b0;
            end else if (ack_cnt_q == ACK_LAST) begin
               err_d[0]      = 1'b1;
               state_d       = S_ABORTING;
               abort_cnt_d   = '0;
               cancel_flag_d = 1'b0;
            end else begin
               ack_cnt_d = ack_cnt_q + ACK_W'(1);
            end
         end
         S_RUNNING: begin
            if (bus.SR_R_FULL)
               err_d[2] = 1'b1;
            if (!status_active) begin
               // Completion wins over a simultaneous index timeout
               run_count_d = run_count_inc;
               if (run_count_inc == target_q || err_q[2] || bus.SR_R_FULL)
                  state_d = S_FINISH;
               else
                  state_d = S_ARM;
            end else if (idx_timeout) begin
               err_d[1]      = 1'b1;
               state_d       = S_ABORTING;
               abort_cnt_d   = '0;
               cancel_flag_d = 1'b0;
            end
         end
         S_ABORTING: begin
            if (abort_cnt_q == ABORT_LAST)
               state_d = cancel_flag_q ? S_IDLE : S_FINISH;
            else
               abort_cnt_d = abort_cnt_q + ABORT_W'(1);
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Host cancel overrides everything: no error bit, no run counted
      if (bus.CANCEL && state_q != S_IDLE && state_q != S_ABORTING) begin
         state_d       = S_ABORTING;
         abort_cnt_d   = '0;
         cancel_flag_d = 1'b1;
         err_d         = err_q;
         run_count_d   = run_count_q;
      end
   end

   // Output decode from the next state so the registered outputs track it
   always_comb begin
      acq_start_d = (state_d == S_ARM);
      acq_abort_d = (state_d == S_ABORTING);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_FINISH);
   end

   assign bus.ACQ_START = acq_start_q;
   assign bus.ACQ_ABORT = acq_abort_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.RUN_COUNT = run_count_q;
   assign bus.ERR       = err_q;
endmodule

// File: tb/tb_acq_run_sequencer.sv
// Bench for the run sequencer: the bench plays the acquisition controller,
// records every cycle, and compares the DUT against a procedural model that
// walks the recorded inputs run by run.
module tb_acq_run_sequencer;
   localparam int ACK_TIMEOUT  = 16;
   localparam int ABORT_CYCLES = 4;
   localparam int MAXC         = 32768;
   localparam int OC_NONE = 0, OC_NEXT = 1, OC_FINISH = 2, OC_ERROR = 3, OC_CANCEL = 4;

   logic clk;
   logic rst;
   acq_run_sequencer_if bus();

   acq_run_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .ABORT_CYCLES(ABORT_CYCLES)) dut (
      .CLK_MASTER(clk),
      .RESET     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // recorded inputs / observed outputs / expected outputs, indexed by cycle
   bit         idx_i [MAXC], wait_i [MAXC], acq_i [MAXC], full_i [MAXC], cancel_i [MAXC];
   logic       o_start [MAXC], o_abort [MAXC], o_busy [MAXC], o_done [MAXC];
   logic [7:0] o_rc [MAXC];
   logic [2:0] o_err [MAXC];
   bit         e_start [MAXC], e_abort [MAXC], e_busy [MAXC], e_done [MAXC];
   logic [7:0] e_rc [MAXC];
   logic [2:0] e_err [MAXC];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int seq_g    = 0;
   logic [7:0] cur_nr, cur_tr;

   // controller-model knobs and schedule
   bit k_respond, k_rand_ctl, k_spur_go;
   int k_d1, k_wlen, k_alen, k_idx_mode, k_idx2, k_full_run, k_cancel_run, k_cancel_off;
   int run_idx, s_cyc, w_from, a_from, c_end;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [14:0] obs(input int c);
      return {o_start[c], o_abort[c], o_busy[c], o_done[c], o_rc[c], o_err[c]};
   endfunction

   task automatic set_ctl(input bit respond, input bit rnd, input int d1, input int wl, input int al,
                          input int idx_mode, input int idx2, input int full_run,
                          input int cancel_run, input int cancel_off, input bit spur_go);
      k_respond = respond; k_rand_ctl = rnd; k_d1 = d1; k_wlen = wl; k_alen = al;
      k_idx_mode = idx_mode; k_idx2 = idx2; k_full_run = full_run;
      k_cancel_run = cancel_run; k_cancel_off = cancel_off; k_spur_go = spur_go;
   endtask

   // Controller behaviour and host stimulus for the current cycle
   task automatic drive_inputs();
      int d1, wl, al;
      bit w, a, idx, full, cncl, go;
      if (o_start[cyc] === 1'b1) begin
         run_idx++;
         s_cyc = cyc;
         if (k_respond) begin
            if (k_rand_ctl) begin
               d1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 6));
               wl = $urandom_range(0, 6);
               al = $urandom_range(1, 20);
            end else begin
               d1 = k_d1; wl = k_wlen; al = k_alen;
            end
            w_from = cyc + d1; a_from = w_from + wl; c_end = a_from + al;
         end else begin
            w_from = 0; a_from = 0; c_end = 0;
         end
      end
      if (o_abort[cyc] === 1'b1) begin
         w_from = 0; a_from = 0; c_end = 0;
      end
      w = (cyc >= w_from) && (cyc < a_from);
      a = (cyc >= a_from) && (cyc < c_end);
      case (k_idx_mode)
         1:       idx = !idx_i[cyc-1] && ($urandom_range(0, 11) == 0);
         2:       idx = (run_idx > 0) && (cyc == s_cyc + 5 || cyc == s_cyc + k_idx2);
         default: idx = 1'b0;
      endcase
      full = (run_idx > 0) && (run_idx == k_full_run) && a && (cyc - a_from < 3);
      cncl = (run_idx > 0) && (run_idx == k_cancel_run) && (cyc == s_cyc + k_cancel_off);
      go   = k_spur_go && (o_busy[cyc] === 1'b1) && (cyc % 3 == 0);
      if (k_spur_go && o_busy[cyc] === 1'b1) begin
         bus.NUM_RUNS     = 8'($urandom_range(0, 255));
         bus.TIMEOUT_REVS = 8'($urandom_range(0, 255));
      end
      idx_i[cyc] = idx; wait_i[cyc] = w; acq_i[cyc] = a; full_i[cyc] = full; cancel_i[cyc] = cncl;
      bus.FD_INDEX_IN = idx; bus.ACQ_WAITING = w; bus.ACQ_ACQUIRING = a;
      bus.SR_R_FULL = full; bus.CANCEL = cncl; bus.GO = go;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= MAXC - 2) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 2);
         $fatal(1, "cycle budget exhausted");
      end
      o_start[cyc] = bus.ACQ_START; o_abort[cyc] = bus.ACQ_ABORT;
      o_busy[cyc]  = bus.BUSY;      o_done[cyc]  = bus.DONE;
      o_rc[cyc]    = bus.RUN_COUNT; o_err[cyc]   = bus.ERR;
      drive_inputs();
   endtask

   function automatic bit rise(input int c);
      return idx_i[c] && !idx_i[c-1];
   endfunction

   task automatic put(input int c, input int last, input int runs, input logic [2:0] err);
      if (c <= last) begin
         e_busy[c] = 1'b1; e_rc[c] = 8'(runs); e_err[c] = err;
      end
   endtask

   // Reference: walk the recorded trace one run at a time from the GO cycle
   task automatic model_seq(input int g, input int last, input logic [7:0] nr, input logic [7:0] tr);
      int c, runs, ack, revs, target, outcome;
      logic [2:0] err;
      bit acked, fin;
      target = (nr == 8'd0) ? 1 : int'(nr);
      runs = 0; err = 3'b000; c = g + 1; fin = 1'b0;
      for (int k = g + 1; k <= last; k++) begin
         e_start[k] = 0; e_abort[k] = 0; e_done[k] = 0; e_busy[k] = 0;
      end
      while (!fin && c <= last) begin
         put(c, last, runs, err);
         e_start[c] = 1'b1;
         outcome = cancel_i[c] ? OC_CANCEL : OC_NONE;
         c++; revs = 0; ack = 0; acked = 1'b0;
         while (outcome == OC_NONE && !acked && c <= last) begin
            put(c, last, runs, err);
            if (cancel_i[c]) outcome = OC_CANCEL;
            else begin
               if (rise(c) && revs < 255) revs++;
               if (wait_i[c] || acq_i[c]) acked = 1'b1;
               else if (tr != 0 && revs >= int'(tr)) begin err[1] = 1'b1; outcome = OC_ERROR; end
               else begin
                  ack++;
                  if (ack == ACK_TIMEOUT) begin err[0] = 1'b1; outcome = OC_ERROR; end
               end
            end
            c++;
         end
         while (outcome == OC_NONE && acked && c <= last) begin
            put(c, last, runs, err);
            if (cancel_i[c]) outcome = OC_CANCEL;
            else begin
               if (rise(c) && revs < 255) revs++;
               if (full_i[c]) err[2] = 1'b1;
               if (!(wait_i[c] || acq_i[c])) begin
                  runs++;
                  outcome = (runs == target || err[2]) ? OC_FINISH : OC_NEXT;
               end else if (tr != 0 && revs >= int'(tr)) begin
                  err[1] = 1'b1; outcome = OC_ERROR;
               end
            end
            c++;
         end
         if (outcome == OC_ERROR || outcome == OC_CANCEL) begin
            for (int k = 0; k < ABORT_CYCLES && c <= last; k++) begin
               put(c, last, runs, err); e_abort[c] = 1'b1; c++;
            end
            if (outcome == OC_CANCEL) fin = 1'b1;
            else outcome = OC_FINISH;
         end
         if (outcome == OC_FINISH && c <= last) begin
            put(c, last, runs, err); e_done[c] = 1'b1;
            if (cancel_i[c]) begin
               c++;
               for (int k = 0; k < ABORT_CYCLES && c <= last; k++) begin
                  put(c, last, runs, err); e_abort[c] = 1'b1; c++;
               end
            end else c++;
            fin = 1'b1;
         end
      end
      for (int k = c; k <= last; k++) begin
         e_rc[k] = 8'(runs); e_err[k] = err;
      end
   endtask

   task automatic start_seq(input logic [7:0] nr, input logic [7:0] tr);
      cur_nr = nr; cur_tr = tr; run_idx = 0; s_cyc = 0;
      bus.NUM_RUNS = nr; bus.TIMEOUT_REVS = tr;
      step();
      bus.GO = 1'b1;
      seq_g = cyc;
   endtask

   // Run until idle, compare per cycle, then optional sequence-level totals
   task automatic run_to_end(input string name, input int x_starts, input int x_aborts,
                             input int x_dones, input int x_rc, input int x_err);
      int idle_run, ns, na, nd;
      idle_run = 0;
      do begin
         step();
         idle_run = (o_busy[cyc] === 1'b0) ? idle_run + 1 : 0;
      end while (idle_run < 4 && cyc < seq_g + 4000);
      check_val({name, "_terminates"}, 32'(idle_run >= 4), 32'd1);
      model_seq(seq_g, cyc, cur_nr, cur_tr);
      ns = 0; na = 0; nd = 0;
      for (int c = seq_g + 1; c <= cyc; c++) begin
         check_val($sformatf("%s_cyc%0d", name, c), 32'(obs(c)),
                   32'({e_start[c], e_abort[c], e_busy[c], e_done[c], e_rc[c], e_err[c]}));
         ns += int'(o_start[c] === 1'b1); na += int'(o_abort[c] === 1'b1); nd += int'(o_done[c] === 1'b1);
      end
      if (x_starts >= 0) check_val({name, "_starts"}, ns, x_starts);
      if (x_aborts >= 0) check_val({name, "_abort_cycles"}, na, x_aborts);
      if (x_dones  >= 0) check_val({name, "_dones"}, nd, x_dones);
      if (x_rc     >= 0) check_val({name, "_run_count"}, 32'(o_rc[cyc]), x_rc);
      if (x_err    >= 0) check_val({name, "_err"}, 32'(o_err[cyc]), x_err);
   endtask

   initial begin
      int sf, af;
      logic [7:0] nr, tr;
      clk = 1'b0; rst = 1'b1;
      bus.GO = 0; bus.CANCEL = 0; bus.NUM_RUNS = 0; bus.TIMEOUT_REVS = 0;
      bus.FD_INDEX_IN = 0; bus.ACQ_WAITING = 0; bus.ACQ_ACQUIRING = 0; bus.SR_R_FULL = 0;
      o_start[0] = 0; o_abort[0] = 0; o_busy[0] = 0; o_done[0] = 0; idx_i[0] = 0;
      run_idx = 0; s_cyc = 0; w_from = 0; a_from = 0; c_end = 0;
      set_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); step();
      check_val("reset_state", 32'(obs(cyc)), 32'd0);
      rst = 1'b0;
      step();

      // three normal runs
      set_ctl(1, 0, 2, 3, 20, 0, 0, 0, 0, 0, 0);
      start_seq(8'd3, 8'd0); run_to_end("t1_three_runs", 3, 0, 1, 3, 0);
      // zero runs treated as one
      start_seq(8'd0, 8'd0); run_to_end("t2_zero_runs", 1, 0, 1, 1, 0);
      // controller silent: ack timeout
      set_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      start_seq(8'd2, 8'd0); run_to_end("t3_ack_timeout", 1, ABORT_CYCLES, 1, 0, 1);
      sf = 0; af = 0;
      for (int c = cyc; c > seq_g; c--) begin
         if (o_start[c] === 1'b1) sf = c;
         if (o_abort[c] === 1'b1) af = c;
      end
      // START (ARM) cycle, then 16 WAIT_ACK cycles, abort visible after them
      check_val("t3_ack_latency", af - sf, ACK_TIMEOUT + 1);
      check_val("t3_err_at_abort", 32'(o_err[af]), 32'd1);
      // index timeout while waiting
      set_ctl(1, 0, 2, 1000, 1, 2, 10, 0, 0, 0, 0);
      start_seq(8'd1, 8'd2); run_to_end("t4_index_timeout", 1, ABORT_CYCLES, 1, 0, 2);
      // completion on the same cycle as the second index edge
      set_ctl(1, 0, 2, 3, 5, 2, 10, 0, 0, 0, 0);
      start_seq(8'd1, 8'd2); run_to_end("t4_completion_wins", 1, 0, 1, 1, 0);
      // cancel during run 1, GO and register changes ignored while busy
      set_ctl(1, 0, 2, 3, 20, 0, 0, 0, 1, 8, 1);
      start_seq(8'd4, 8'd0); run_to_end("t6_cancel", 1, ABORT_CYCLES, 0, 0, 0);
      // RAM full during run 2
      set_ctl(1, 0, 2, 3, 10, 0, 0, 2, 0, 0, 0);
      start_seq(8'd5, 8'd0); run_to_end("t5_ram_full", 2, 0, 1, 2, 4);
      // reset while running
      set_ctl(1, 0, 2, 2, 30, 0, 0, 0, 0, 0, 0);
      start_seq(8'd4, 8'd0);
      repeat (10) step();
      check_val("t7_busy_before_reset", 32'(o_busy[cyc]), 32'd1);
      rst = 1'b1;
      step();
      check_val("t7_outputs_after_reset", 32'(obs(cyc)), 32'd0);
      rst = 1'b0; w_from = 0; a_from = 0; c_end = 0;
      step(); step();
      check_val("t7_idle_after_reset", 32'(obs(cyc)), 32'd0);

      // randomized sequences
      for (int n = 0; n < 30; n++) begin
         set_ctl($urandom_range(0, 9) != 0, 1, 0, 0, 0, int'($urandom_range(0, 1)), 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
                 int'($urandom_range(0, 30)), $urandom_range(0, 1) != 0);
         nr = 8'($urandom_range(0, 5));
         tr = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(1, 4));
         start_seq(nr, tr);
         run_to_end($sformatf("rand%0d", n), -1, -1, -1, -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
